distance_smoother: RTL and testbench
====================================

Name: distance_smoother

Overview:
- Downstream of the ultrasonic distance sensor; sits between its relative-distance output and the seven-segment and LCD consumers.
- Keeps a moving average over the last 2^LOG2_DEPTH accepted samples.
- Drives a registered smoothed distance with a one-cycle valid strobe.
- Drives a "near" flag with hysteresis for screen and LED logic.

Parameters:
- W, 16: sample and output width.
- LOG2_DEPTH, 3: log2 of the averaging window (window = 8 samples); legal range 1..6.
- NEAR_THRESH, 16'd400: near asserts when the average is below this value.
- NEAR_HYST, 16'd40: near deasserts when the average is at or above NEAR_THRESH + NEAR_HYST.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous reset, active low.
- in_valid, input, 1: one-cycle strobe, new sample present on in_distance.
- in_distance, input, W: raw relative distance.
- flush, input, 1: discard history and return to EMPTY.
- out_valid, output, 1: one-cycle strobe, out_distance updated.
- out_distance, output, W: smoothed distance (registered).
- near, output, 1: proximity flag with hysteresis (registered).
- fill, output, LOG2_DEPTH+1: number of real samples in the window, saturating at 2^LOG2_DEPTH.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_distance=0, near=0, fill=0.
  - state=EMPTY; write pointer=0; sum=0.
  - Buffer contents are don't-care.
- State machine, two states: EMPTY and RUN.
- EMPTY, accepted sample s:
  - All 2^LOG2_DEPTH buffer entries are preloaded with s.
  - sum = s << LOG2_DEPTH; pointer=0; fill=1; go to RUN.
  - out_distance=s and out_valid=1 on the same edge.
- RUN, accepted sample s:
  - next_sum = sum + s − buf[ptr]; buf[ptr] = s.
  - ptr = ptr+1, wrapping modulo 2^LOG2_DEPTH.
  - fill = min(fill+1, 2^LOG2_DEPTH).
  - out_distance = next_sum >> LOG2_DEPTH (truncating), out_valid=1.
- Latency: out_valid rises exactly 1 clock after the in_valid cycle. One sample per cycle is sustainable (back-to-back in_valid allowed).
- Width: sum is W+LOG2_DEPTH bits unsigned, so it never overflows. out_distance is always ≤ 2^W−1.
- near, updated only on edges where out_valid is set, evaluated on the new out_distance:
  - if out_distance < NEAR_THRESH then near=1;
  - else if out_distance ≥ NEAR_THRESH+NEAR_HYST then near=0;
  - else near holds.
  - The threshold sum is computed at W+1 bits.
- flush without in_valid:
  - state=EMPTY, fill=0, out_valid=0.
  - out_distance and near hold their last values.
- flush together with in_valid: treated as EMPTY plus that sample. The buffer is preloaded with in_distance, out_valid=1, fill=1.
- Reset mid-stream: all history is lost; the first sample after reset takes the preload path.
- in_valid while rst_n is low is ignored.

Optional Feature:
- Macro: DISTANCE_SMOOTHER_OUTLIER_REJECT_EN.
- Defined:
  - Samples equal to 0 or all-ones (sensor timeout or no-echo codes) are rejected.
  - A rejected sample causes no buffer write, no pointer or fill change and no out_valid.
  - An extra output, rejected_count (8 bits, saturating at 255, reset 0), increments on each rejected sample; flush clears it.
- Undefined: every in_valid sample is accepted, and the rejected_count port is absent.

Decomposition:
- Package distance_pkg:
  - typedef distance_t (logic [15:0]);
  - state enum smoother_state_t {EMPTY, RUN};
  - default NEAR_THRESH and NEAR_HYST localparams, shared with the display logic.
- One sub-module, distance_window_buf:
  - 2^LOG2_DEPTH × W register file with a wrapping write pointer;
  - preload-all port;
  - combinational read of the oldest entry at ptr.
- The FSM, sum, averaging and hysteresis stay in distance_smoother.

Test Plan:
- Preload: after reset, in_valid with 1000 → next cycle out_valid=1, out_distance=1000, fill=1, near=0.
- Window average: preload 1000, then eight samples of 200 back-to-back.
  - Outputs are 900, 800, 700, 600, 500, 400, 300, 200, one per cycle.
  - fill saturates at 8.
- Hysteresis (NEAR_THRESH=400, NEAR_HYST=40):
  - averages 399 → near=1; 420 → near stays 1; 440 → near=0; 420 → near stays 0.
  - Drive each average by flush with in_valid.
- Flush:
  - flush alone → out_valid=0, fill=0, out_distance holds.
  - flush with in_valid=50 → out_distance=50, buffer all 50.
- Async reset mid-stream: assert rst_n low between clock edges.
  - Outputs clear immediately, without waiting for a clock edge.
  - The next sample of 300 yields out_distance=300.
- With DISTANCE_SMOOTHER_OUTLIER_REJECT_EN defined: samples 0 and 16'hFFFF produce no out_valid and rejected_count=2; the next sample of 500 averages normally.

Source files
------------

// File: rtl/distance_pkg.sv
// -----------------------------------------------------------------------------
// distance_pkg
// Shared types and constants for the distance smoothing path. The near
// threshold and hysteresis defaults live here so the display logic and the
// smoother agree on what "near" means.
// -----------------------------------------------------------------------------
package distance_pkg;

    typedef logic [15:0] distance_t;

    typedef enum logic {
        EMPTY = 1'b0,   // no history, next accepted sample preloads the window
        RUN   = 1'b1    // window holds history, sliding average active
    } smoother_state_t;

    localparam distance_t DEFAULT_NEAR_THRESH = 16'd400;
    localparam distance_t DEFAULT_NEAR_HYST   = 16'd40;

    localparam logic [7:0] REJECT_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/distance_smoother_if.sv
// -----------------------------------------------------------------------------
// distance_smoother_if
// Sample stream in, smoothed stream out.
//   in_valid/in_distance : one-cycle sample strobe and raw distance
//   flush                : drop history, return smoother to EMPTY
//   out_valid/out_distance: one-cycle strobe and registered average
//   near                 : proximity flag with hysteresis
//   fill                 : real samples in the window (saturating)
//   rejected_count       : only with DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
// Modports: master drives samples (sensor side), slave is the smoother.
// -----------------------------------------------------------------------------
interface distance_smoother_if #(
    parameter int W          = 16,
    parameter int LOG2_DEPTH = 3
);
    logic                  in_valid;
    logic [W-1:0]          in_distance;
    logic                  flush;
    logic                  out_valid;
    logic [W-1:0]          out_distance;
    logic                  near;
    logic [LOG2_DEPTH:0]   fill;
`ifdef DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
    logic [7:0]            rejected_count;

    modport master (
        output in_valid, in_distance, flush,
        input  out_valid, out_distance, near, fill, rejected_count
    );
    modport slave (
        input  in_valid, in_distance, flush,
        output out_valid, out_distance, near, fill, rejected_count
    );
`else
    modport master (
        output in_valid, in_distance, flush,
        input  out_valid, out_distance, near, fill
    );
    modport slave (
        input  in_valid, in_distance, flush,
        output out_valid, out_distance, near, fill
    );
`endif
endinterface

// File: rtl/distance_window_buf.sv
// -----------------------------------------------------------------------------
// distance_window_buf
// 2^LOG2_DEPTH x W sample history with a wrapping write pointer.
//   clk, rst_n : clock, async active-low reset (pointer only)
//   preload    : write wr_data into every entry, pointer back to 0
//   wr_en      : write wr_data at the pointer, pointer advances
//   wr_data    : sample to store
//   rd_data    : entry at the pointer, i.e. the oldest sample (combinational)
// -----------------------------------------------------------------------------
module distance_window_buf #(
    parameter int W          = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         preload,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data
);
    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [W-1:0]          mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (preload)    ptr_d = '0;
        else if (wr_en) ptr_d = ptr_q + LOG2_DEPTH'(1);   // wraps naturally
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    // meaningless until the first preload, and leaving it out keeps it a
    // plain register file rather than DEPTH*W reset flops.
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= wr_data;
        end else if (wr_en) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[ptr_q];

endmodule

// File: rtl/distance_smoother.sv
// -----------------------------------------------------------------------------
// distance_smoother
// Moving average over the last 2^LOG2_DEPTH accepted distance samples, with a
// hysteretic "near" flag.
//   clk, rst_n : clock, async active-low reset
//   bus        : distance_smoother_if.slave (samples in, smoothed stream out)
// The first sample after reset or flush preloads the whole window, so the
// average is meaningful from the first output.
// Optional: DISTANCE_SMOOTHER_OUTLIER_REJECT_EN drops samples equal to 0 or
// all-ones and counts them on bus.rejected_count.
// -----------------------------------------------------------------------------
module distance_smoother
    import distance_pkg::*;
#(
    parameter int        W           = 16,
    parameter int        LOG2_DEPTH  = 3,
    parameter distance_t NEAR_THRESH = DEFAULT_NEAR_THRESH,
    parameter distance_t NEAR_HYST   = DEFAULT_NEAR_HYST
) (
    input  logic         clk,
    input  logic         rst_n,
    distance_smoother_if.slave bus
);
    localparam int                  SUM_W    = W + LOG2_DEPTH;
    localparam int                  DEPTH    = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_MAX = DEPTH[LOG2_DEPTH:0];
    // Thresholds compared at W+1 bits so THRESH+HYST cannot wrap.
    localparam logic [W:0]          NEAR_LO  = (W+1)'(NEAR_THRESH);
    localparam logic [W:0]          NEAR_HI  = (W+1)'(NEAR_THRESH) + (W+1)'(NEAR_HYST);

    smoother_state_t     state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [LOG2_DEPTH:0] fill_q, fill_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        out_distance_q, out_distance_d;
    logic                near_q, near_d;

    logic                accept;
    logic                preload;
    logic                wr_en;
    logic [W-1:0]        oldest;

`ifdef DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
    logic [7:0]          rej_q, rej_d;
    logic                rejected;

    assign accept   = bus.in_valid && (bus.in_distance != '0) && (bus.in_distance != '1);
    assign rejected = bus.in_valid && !accept;
`else
    assign accept   = bus.in_valid;
`endif

    // A flush coinciding with a sample restarts the window from that sample.
    assign preload = accept && (bus.flush || state_q == EMPTY);
    assign wr_en   = accept && !preload;

    distance_window_buf #(
        .W          (W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .preload (preload),
        .wr_en   (wr_en),
        .wr_data (bus.in_distance),
        .rd_data (oldest)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        fill_d         = fill_q;
        out_valid_d    = 1'b0;
        out_distance_d = out_distance_q;
        near_d         = near_q;

        if (bus.flush) begin
            state_d = EMPTY;
            fill_d  = '0;
        end

        if (preload) begin
            state_d        = RUN;
            sum_d          = {bus.in_distance, LOG2_DEPTH'(0)};
            fill_d         = (LOG2_DEPTH+1)'(1);
            out_valid_d    = 1'b1;
            out_distance_d = bus.in_distance;
        end else if (wr_en) begin
            // The sum always contains the oldest entry, so the subtraction
            // cannot go negative.
            sum_d          = sum_q + SUM_W'(bus.in_distance) - SUM_W'(oldest);
            fill_d         = (fill_q == FILL_MAX) ? fill_q : fill_q + (LOG2_DEPTH+1)'(1);
            out_valid_d    = 1'b1;
            out_distance_d = sum_d[SUM_W-1:LOG2_DEPTH];
        end

        if (out_valid_d) begin
            if ({1'b0, out_distance_d} < NEAR_LO)       near_d = 1'b1;
            else if ({1'b0, out_distance_d} >= NEAR_HI) near_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EMPTY;
            sum_q          <= '0;
            fill_q         <= '0;
            out_valid_q    <= 1'b0;
            out_distance_q <= '0;
            near_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            fill_q         <= fill_d;
            out_valid_q    <= out_valid_d;
            out_distance_q <= out_distance_d;
            near_q         <= near_d;
        end
    end

`ifdef DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
    // Flush clears the count; a rejected sample in the same cycle counts
    // against the fresh window.
    always_comb begin
        rej_d = bus.flush ? 8'd0 : rej_q;
        if (rejected && rej_d != REJECT_COUNT_MAX) rej_d = rej_d + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rej_q <= '0;
        else        rej_q <= rej_d;
    end

    assign bus.rejected_count = rej_q;
`endif

    assign bus.out_valid    = out_valid_q;
    assign bus.out_distance = out_distance_q;
    assign bus.near         = near_q;
    assign bus.fill         = fill_q;

endmodule

// File: tb/tb_distance_smoother.sv
// -----------------------------------------------------------------------------
// tb_distance_smoother
// Directed vector table, hand-written reset/outlier sequences, and random
// stimulus compared against a queue-based model of the averaging window.
// -----------------------------------------------------------------------------
module tb_distance_smoother;

    localparam int W     = 16;
    localparam int LOG2  = 3;
    localparam int DEPTH = 1 << LOG2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    distance_smoother_if #(.W(W), .LOG2_DEPTH(LOG2)) bus ();

    distance_smoother #(
        .W          (W),
        .LOG2_DEPTH (LOG2),
        .NEAR_THRESH(16'd400),
        .NEAR_HYST  (16'd40)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic apply(input logic v, input logic f, input logic [15:0] d);
        bus.in_valid    = v;
        bus.flush       = f;
        bus.in_distance = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [15:0] ed,
                              input logic en, input logic [3:0] ef);
        check({tag, ".out_valid"},    32'(bus.out_valid),    32'(ev));
        check({tag, ".out_distance"}, 32'(bus.out_distance), 32'(ed));
        check({tag, ".near"},         32'(bus.near),         32'(en));
        check({tag, ".fill"},         32'(bus.fill),         32'(ef));
    endtask

    // ---------------- reference model ----------------
    logic [15:0] win[$];
    bit          m_empty;
    int          m_fill;
    logic        m_valid;
    logic [15:0] m_dist;
    logic        m_near;
    int          m_rej;

    task automatic model_reset();
        win.delete();
        m_empty = 1'b1;
        m_fill  = 0;
        m_valid = 1'b0;
        m_dist  = '0;
        m_near  = 1'b0;
        m_rej   = 0;
    endtask

    task automatic model_step(input logic v, input logic f, input logic [15:0] d);
        bit ok;
        int unsigned total;
        ok = v;
`ifdef DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
        ok = v && d != 16'h0000 && d != 16'hFFFF;
`endif
        m_valid = 1'b0;
        if (f) begin
            m_empty = 1'b1;
            m_fill  = 0;
            m_rej   = 0;
        end
        if (v && !ok && m_rej < 255) m_rej++;
        if (ok) begin
            if (m_empty) begin
                win.delete();
                repeat (DEPTH) win.push_back(d);
                m_empty = 1'b0;
                m_fill  = 1;
            end else begin
                void'(win.pop_front());
                win.push_back(d);
                m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
            end
            total = 0;
            foreach (win[i]) total += win[i];
            m_dist  = 16'(total / DEPTH);
            m_valid = 1'b1;
            if (m_dist < 400)       m_near = 1'b1;
            else if (m_dist >= 440) m_near = 1'b0;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic        f;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic        en;
        logic [3:0]  ef;
    } vec_t;

    localparam int NTBL = 18;
    vec_t tbl[NTBL];

    initial begin
        // preload, then eight 200s sliding through the window
        tbl[0]  = '{1'b1, 1'b0, 16'd1000, 1'b1, 16'd1000, 1'b0, 4'd1};
        tbl[1]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd900,  1'b0, 4'd2};
        tbl[2]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd800,  1'b0, 4'd3};
        tbl[3]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd700,  1'b0, 4'd4};
        tbl[4]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd600,  1'b0, 4'd5};
        tbl[5]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd500,  1'b0, 4'd6};
        tbl[6]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd400,  1'b0, 4'd7};
        tbl[7]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd300,  1'b1, 4'd8};
        tbl[8]  = '{1'b1, 1'b0, 16'd200,  1'b1, 16'd200,  1'b1, 4'd8};
        // hysteresis via flush+sample
        tbl[9]  = '{1'b1, 1'b1, 16'd399,  1'b1, 16'd399,  1'b1, 4'd1};
        tbl[10] = '{1'b1, 1'b1, 16'd420,  1'b1, 16'd420,  1'b1, 4'd1};
        tbl[11] = '{1'b1, 1'b1, 16'd440,  1'b1, 16'd440,  1'b0, 4'd1};
        tbl[12] = '{1'b1, 1'b1, 16'd420,  1'b1, 16'd420,  1'b0, 4'd1};
        // flush alone holds distance/near
        tbl[13] = '{1'b0, 1'b1, 16'd0,    1'b0, 16'd420,  1'b0, 4'd0};
        // flush with sample preloads all entries with 50
        tbl[14] = '{1'b1, 1'b1, 16'd50,   1'b1, 16'd50,   1'b1, 4'd1};
        tbl[15] = '{1'b1, 1'b0, 16'd50,   1'b1, 16'd50,   1'b1, 4'd2};
        tbl[16] = '{1'b1, 1'b0, 16'd130,  1'b1, 16'd60,   1'b1, 4'd3};
        // idle: strobe drops, values hold
        tbl[17] = '{1'b0, 1'b0, 16'd0,    1'b0, 16'd60,   1'b1, 4'd3};
    end

    initial begin
        logic v, f;
        logic [15:0] d;

        // reset with a sample present: must be ignored
        rst_n           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.flush       = 1'b0;
        bus.in_distance = 16'd1234;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 16'd0, 1'b0, 4'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 16'd0);
        check_outs("post_reset_idle", 1'b0, 16'd0, 1'b0, 4'd0);

        for (int i = 0; i < NTBL; i++) begin
            apply(tbl[i].v, tbl[i].f, tbl[i].d);
            check_outs($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].en, tbl[i].ef);
        end

        // async reset between edges while out_valid is high
        apply(1'b1, 1'b0, 16'd1000);
        check("pre_rst.out_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 16'd0, 1'b0, 4'd0);
        #2 rst_n = 1'b1;
        apply(1'b1, 1'b0, 16'd300);
        check_outs("after_rst", 1'b1, 16'd300, 1'b1, 4'd1);
        apply(1'b1, 1'b0, 16'd900);
        check_outs("after_rst2", 1'b1, 16'd375, 1'b1, 4'd2);

`ifdef DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
        apply(1'b0, 1'b1, 16'd0);
        check("rej_clear", 32'(bus.rejected_count), 32'd0);
        apply(1'b1, 1'b0, 16'h0000);
        check("rej0.out_valid", 32'(bus.out_valid), 32'd0);
        check("rej0.count", 32'(bus.rejected_count), 32'd1);
        apply(1'b1, 1'b0, 16'hFFFF);
        check("rejF.out_valid", 32'(bus.out_valid), 32'd0);
        check("rejF.count", 32'(bus.rejected_count), 32'd2);
        apply(1'b1, 1'b0, 16'd500);
        check_outs("rej_next", 1'b1, 16'd500, 1'b0, 4'd1);
        check("rej_next.count", 32'(bus.rejected_count), 32'd2);
`endif

        // random stimulus against the model, from a clean reset
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                2, 3, 4: d = 16'($urandom_range(300, 500));
                default: d = 16'($urandom);
            endcase
            model_step(v, f, d);
            apply(v, f, d);
            check_outs($sformatf("rnd%0d", n), m_valid, m_dist, m_near, 4'(m_fill));
`ifdef DISTANCE_SMOOTHER_OUTLIER_REJECT_EN
            check($sformatf("rnd%0d.rej", n), 32'(bus.rejected_count), 32'(m_rej));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
